// File: rtl/mem_arbiter_if.sv
// Requester-side bus shared by the CPU datapath and the debug loader ports of mem_arbiter.
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        funct3;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter: round-robin access to one sync-read memory for cpu and dbg, |
// | with a bounded bus lock that lets dbg run atomic multi-word sequences.   |
// | Revision: 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 64
) (
  input  wire logic              clk,
  input  wire logic              reset,
  mem_arbiter_if.slave           cpu,
  mem_arbiter_if.slave           dbg,
  input  wire logic              dbg_lock,
  output logic                   mem_wren,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [2:0]             mem_funct3,
  input  wire logic [DATA_W-1:0] mem_rdata,
  output logic                   lock_timeout
);

  localparam int            CNT_W   = $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    LOCKED  = 2'd1,
    EXPIRED = 2'd2
  } lock_state_t;

  lock_state_t      state;
  lock_state_t      state_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic             last_dbg;
  logic             expire;
  logic             grant_cpu;
  logic             grant_dbg;
  logic             rvalid_cpu;
  logic             rvalid_dbg;

  // Ties go to whichever port was not granted last; a lock shuts the CPU out.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state == LOCKED) begin
      grant_dbg = dbg.req;
    end else if (cpu.req && (!dbg.req || last_dbg)) begin
      grant_cpu = 1'b1;
    end else if (dbg.req) begin
      grant_dbg = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    expire    = 1'b0;
    case (state)
      OPEN: begin
        if (grant_dbg && dbg_lock) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!dbg_lock) begin
          state_nxt = OPEN;
        end else if (lock_cnt == CNT_MAX) begin
          state_nxt = EXPIRED;
          expire    = 1'b1;
        end
      end
      EXPIRED: begin
        if (!dbg_lock) state_nxt = OPEN;
      end
      default: state_nxt = OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= OPEN;
      lock_cnt     <= '0;
      last_dbg     <= 1'b1;
      rvalid_cpu   <= 1'b0;
      rvalid_dbg   <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      lock_timeout <= expire;
      rvalid_cpu   <= grant_cpu && !cpu.we;
      rvalid_dbg   <= grant_dbg && !dbg.we;
      // Held at zero outside LOCKED, so entering LOCKED always starts from 0.
      if (state != LOCKED) begin
        lock_cnt <= '0;
      end else if (lock_cnt != CNT_MAX) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      if (grant_dbg) begin
        last_dbg <= 1'b1;
      end else if (grant_cpu) begin
        last_dbg <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b010;
    if (grant_cpu) begin
      mem_wren   = cpu.we;
      mem_addr   = cpu.addr;
      mem_wdata  = cpu.wdata;
      mem_funct3 = cpu.funct3;
    end else if (grant_dbg) begin
      mem_wren   = dbg.we;
      mem_addr   = dbg.addr;
      mem_wdata  = dbg.wdata;
      mem_funct3 = dbg.funct3;
    end
  end

  assign cpu.gnt    = grant_cpu;
  assign dbg.gnt    = grant_dbg;
  assign cpu.rvalid = rvalid_cpu;
  assign dbg.rvalid = rvalid_dbg;
  assign cpu.rdata  = mem_rdata;
  assign dbg.rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single synchronous-read `memory` instance between the CPU datapath (port `cpu`) and a debug/program loader (port `dbg`). It sits between `top` and `memory`. It replaces the direct address and write-enable wiring with a round-robin grant, and adds a bounded bus-lock so the loader can perform atomic multi-word sequences. The CPU control FSM must hold `pc_en`/`inst_en` until `cpu_gnt` and `cpu_rvalid` indicate that its access completed.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_LOCK`, 64, maximum consecutive cycles `dbg` may hold the lock (≥2)

- `clk`  input  1  system clock; all state changes on the rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = in reset)
- `cpu_req`  input  1  CPU requests an access this cycle
- `cpu_we`  input  1  1 = write, 0 = read
- `cpu_addr`  input  ADDR_W  byte address
- `cpu_wdata`  input  DATA_W  write data
- `cpu_funct3`  input  3  access size/sign code, passed through to memory
- `cpu_gnt`  output  1  combinational; the access is issued this cycle
- `cpu_rvalid`  output  1  read data valid; registered
- `cpu_rdata`  output  DATA_W  read data, meaningful only while `cpu_rvalid` = 1
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_funct3`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`  same meanings as the `cpu_*` set
- `dbg_lock`  input  1  requests exclusive ownership, starting from the next `dbg` grant
- `mem_wren`  output  1  memory write enable
- `mem_addr`  output  ADDR_W  memory read/write address
- `mem_wdata`  output  DATA_W  memory write data
- `mem_funct3`  output  3  memory access code
- `mem_rdata`  input  DATA_W  memory read data, valid 1 cycle after the address
- `lock_timeout`  output  1  one-cycle pulse when a lock is forcibly expired

## Operation
- **Lock FSM states:**
  - OPEN: normal round-robin.
  - LOCKED: only `dbg` can be granted; `cpu_gnt` = 0.
  - EXPIRED: round-robin, and `dbg_lock` is ignored.
- **Lock FSM transitions:**
  - OPEN→LOCKED at the edge ending a cycle where `dbg_gnt` = 1 and `dbg_lock` = 1.
  - LOCKED→OPEN at the edge ending a cycle where `dbg_lock` = 0.
  - LOCKED→EXPIRED when `lock_cnt` = MAX_LOCK−1 and `dbg_lock` = 1; `lock_timeout` = 1 for the first EXPIRED cycle.
  - EXPIRED→OPEN at the edge ending a cycle where `dbg_lock` = 0.
- `lock_cnt`: cleared on entry to LOCKED, +1 per LOCKED cycle, saturates at MAX_LOCK−1. It never wraps.
- **Grant in OPEN/EXPIRED:**
  - Only one port requesting: that port is granted.
  - Both ports requesting: grant the port that is not `last_gnt`.
  - No request: neither port is granted.
  - `last_gnt` updates on every grant.
- **Grant in LOCKED:** `dbg_gnt` = `dbg_req`; CPU requests wait, and `cpu_gnt` stays 0.
- At most one grant per cycle; the grants are mutually exclusive.
- **Memory mux:**
  - While a port is granted, `mem_*` take that port's signals, with `mem_wren` = granted `we`.
  - With no grant: `mem_wren` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_funct3` = 3'b010.
- **Read return:**
  - A granted read (`we` = 0) in cycle N sets that port's `rvalid` = 1 in cycle N+1.
  - Both `*_rdata` outputs = `mem_rdata`.
  - Writes produce no `rvalid`.
- Back-to-back accesses are allowed: one grant per cycle, with `rvalid` pipelined one cycle behind.

## Timing
- **Reset (asserted, `reset` = 0):**
  - State = OPEN, `last_gnt` = dbg (so the CPU wins the first tie), `lock_cnt` = 0.
  - `cpu_rvalid` = `dbg_rvalid` = 0, `lock_timeout` = 0.
  - Grants and `mem_*` follow the combinational rules using the reset state.
- Reset in mid-operation clears any pending `rvalid` and any lock. No read data is returned for accesses issued before reset.
- Latency from request to grant: 0 cycles when uncontended. Read latency from grant: 1 cycle.
- Worst-case CPU wait: 1 cycle in OPEN, or MAX_LOCK+1 cycles while a lock is held.
- Requesters hold `req` and the payload stable until they see `gnt`. The arbiter does not latch an ungranted request.
- `dbg_lock` deasserting in the same cycle as a `dbg` grant: no lock is taken, or an existing lock is released at that edge.

## Test plan
- **Reset:** hold `reset` = 0 with both ports requesting, then release. Required: in the first cycle after release, `cpu_gnt` = 1; no `rvalid` while `reset` = 0.
- **Contention:** both ports issue reads continuously to 0x10 (CPU) and 0x20 (dbg). Required: grants alternate cpu, dbg, cpu…; `mem_addr` follows 0x10, 0x20…; each `rvalid` arrives 1 cycle after its grant, on the correct port only.
- **Write pass-through:** CPU writes 0xDEADBEEF to 0x40 with `funct3` = 010, then reads it back. Required: `mem_wren` = 1 only in the write cycle; `cpu_rvalid` with data 0xDEADBEEF; `dbg_rvalid` stays 0.
- **Lock with normal release:** dbg holds `dbg_lock` = 1 for 5 granted accesses while the CPU requests continuously. Required: `cpu_gnt` = 0 throughout the lock; the CPU is granted in the first cycle after `dbg_lock` falls.
- **Lock timeout:** with MAX_LOCK = 4, dbg holds `dbg_lock` = 1 indefinitely while both ports request. Required:
  - `lock_timeout` pulses for exactly 1 cycle after 4 LOCKED cycles.
  - Grants then alternate.
  - No re-lock until `dbg_lock` drops for one cycle.
- **Reset with a read in flight:** assert `reset` in the cycle after a granted dbg read. Required: `dbg_rvalid` = 0 immediately; state = OPEN after release.
